key_debounce_repeat: RTL
========================

KEY_DEBOUNCE_REPEAT -- requirements
Module: key_debounce_repeat

Interface
REQ-001 SHALL have parameter w_key, default 8: number of keys handled in parallel.
REQ-002 SHALL have parameter debounce_cycles, default 250000: stable cycles required to accept a change (10 ms at 25 MHz); legal values are 1 or more.
REQ-003 SHALL have parameter repeat_delay_cycles, default 12500000: held cycles from the press pulse to the first repeat pulse; legal values are 1 or more.
REQ-004 SHALL have parameter repeat_period_cycles, default 2500000: cycles between successive repeat pulses; legal values are 1 or more.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port key_raw, input, w_key bits: raw key levels from the TM1638 board controller, 1 = pressed, asynchronous to clock and bouncy.
REQ-008 SHALL have port repeat_en, input, 1 bit: global auto-repeat enable.
REQ-009 SHALL have port key_level, output, w_key bits: debounced key levels.
REQ-010 SHALL have port key_press, output, w_key bits: one-cycle pulse per key on each debounced 0->1 transition.
REQ-011 SHALL have port key_release, output, w_key bits: one-cycle pulse per key on each debounced 1->0 transition.
REQ-012 SHALL have port key_repeat, output, w_key bits: one-cycle auto-repeat pulse per key.
REQ-013 SHALL have port any_key, output, 1 bit: OR of all key_level bits.

Function
REQ-014 SHALL pass each key_raw bit through a 2-flop synchronizer before any other logic; the result is called sync.
REQ-015 SHALL keep, per key, an independent debounce counter sized to hold debounce_cycles-1.
REQ-016 SHALL increment a key's debounce counter each cycle that sync differs from key_level, and clear it in any cycle that sync equals key_level, so bounces restart the count.
REQ-017 SHALL, when the counter equals debounce_cycles-1 and sync still differs, invert key_level on that clock edge and clear the counter; a stable raw change therefore reaches key_level exactly 2+debounce_cycles edges after it is first sampled.
REQ-018 SHALL reject any raw pulse or glitch shorter than debounce_cycles synchronized cycles, leaving key_level, key_press and key_release unchanged.
REQ-019 SHALL register key_press and key_release so they assert in the same cycle key_level changes and last exactly one cycle.
REQ-020 SHALL give each key a 2-state repeat FSM, DELAY and PERIOD, plus a hold counter wide enough for max(repeat_delay_cycles, repeat_period_cycles).
REQ-021 SHALL load the hold counter to 0 and enter DELAY on the press pulse.
REQ-022 SHALL, while key_level=1 and repeat_en=1, increment the hold counter each cycle.
REQ-023 SHALL, in DELAY, pulse key_repeat when the count reaches repeat_delay_cycles, then clear the counter and enter PERIOD.
REQ-024 SHALL, in PERIOD, pulse key_repeat each time the count reaches repeat_period_cycles, then clear the counter.
REQ-025 SHALL hold the counter at 0 in DELAY state while repeat_en=0, so re-enabling restarts the full delay; key_repeat stays 0 throughout.
REQ-026 SHALL never assert key_repeat in a cycle where key_level is 0 or key_release is 1; release returns the FSM to DELAY with the counter cleared.
REQ-027 SHALL process keys fully independently, so simultaneous presses, releases or repeats on different keys each produce their own pulses in the same cycle.
REQ-028 SHALL register any_key and update it in the same cycle as key_level.

Reset
REQ-029 SHALL, on a clock edge with reset=1, clear the synchronizer flops, all counters, key_level, key_press, key_release, key_repeat and any_key to 0, and place every FSM in DELAY.
REQ-030 SHALL, when reset is released while a key is still held, treat the key as a new press: key_press asserts 2+debounce_cycles edges later, with no key_release generated by the reset.

Verification (debounce_cycles=4, repeat_delay_cycles=20, repeat_period_cycles=8, w_key=8)
REQ-031 SHALL cover this press scenario: key_raw[0] rises and is held -> key_press[0] pulses one cycle and key_level[0]=1 and any_key=1 at edge 6 after the first sample.
REQ-032 SHALL cover this bounce scenario: key_raw[0] toggles 1,0,1,0 with 3-cycle high and 2-cycle low phases, then holds high -> no output activity during the bounce, then key_press[0] at edge 6 after the final rise.
REQ-033 SHALL cover this repeat scenario: repeat_en=1 and key 0 held -> key_repeat[0] at press+20, +28 and +36, with no repeat if repeat_en=0.
REQ-034 SHALL cover this release scenario: key_raw[0] falls during PERIOD -> key_release[0] at edge 6 after the fall, key_level[0]=0, and no further key_repeat[0].
REQ-035 SHALL cover this simultaneous-event scenario: key_raw=8'h81 rises in one cycle -> key_press=8'h81 in a single cycle, and releasing key 7 only leaves any_key=1.
REQ-036 SHALL cover this reset-during-hold scenario: reset pulses while key 3 is held -> all outputs 0 on the next cycle, then key_press[3] at edge 6 after reset deasserts.

Source files
------------

// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat
// Debounces a vector of raw key levels (TM1638 board scan, 1 = pressed) and
// derives per-key press/release pulses plus a typematic auto-repeat pulse.
//
// Ports:
//   clock       - single clock, all state updates on its rising edge
//   reset       - synchronous, active-high reset
//   key_raw     - raw, asynchronous, bouncy key levels (w_key bits)
//   repeat_en   - global auto-repeat enable
//   key_level   - debounced key levels
//   key_press   - one-cycle pulse on each debounced 0->1 transition
//   key_release - one-cycle pulse on each debounced 1->0 transition
//   key_repeat  - one-cycle auto-repeat pulse while a key is held
//   any_key     - OR of all debounced key levels (registered)
module key_debounce_repeat #(
    parameter int w_key                = 8,
    parameter int debounce_cycles      = 250000,
    parameter int repeat_delay_cycles  = 12500000,
    parameter int repeat_period_cycles = 2500000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [w_key-1:0] key_raw,
    input  logic             repeat_en,
    output logic [w_key-1:0] key_level,
    output logic [w_key-1:0] key_press,
    output logic [w_key-1:0] key_release,
    output logic [w_key-1:0] key_repeat,
    output logic             any_key
);

    // The debounce counter only ever holds 0 .. debounce_cycles-1.
    localparam int db_width = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
    localparam logic [db_width-1:0] db_last = db_width'(debounce_cycles - 1);

    // The hold counter must be able to represent the larger repeat interval.
    localparam int hold_max   = (repeat_delay_cycles > repeat_period_cycles) ?
                                repeat_delay_cycles : repeat_period_cycles;
    localparam int hold_width = $clog2(hold_max + 1);
    localparam logic [hold_width-1:0] delay_target  = hold_width'(repeat_delay_cycles);
    localparam logic [hold_width-1:0] period_target = hold_width'(repeat_period_cycles);

    typedef enum logic {
        DELAY  = 1'b0,
        PERIOD = 1'b1
    } rep_state_t;

    logic [w_key-1:0]      sync_meta;
    logic [w_key-1:0]      sync;
    logic [w_key-1:0]      flip;
    logic [w_key-1:0]      level_next;
    logic [w_key-1:0]      hold_hit;
    logic [db_width-1:0]   db_count   [w_key];
    logic [hold_width-1:0] hold_count [w_key];
    logic [hold_width-1:0] hold_next  [w_key];
    rep_state_t            rep_state  [w_key];

    // Per-key decode: a key flips its debounced level when the synchronized
    // value has disagreed for debounce_cycles consecutive cycles. hold_hit
    // marks the cycle in which the hold count reaches the interval that
    // belongs to the current repeat state.
    always_comb begin
        flip     = '0;
        hold_hit = '0;
        for (int i = 0; i < w_key; i++) begin
            flip[i]      = (sync[i] != key_level[i]) && (db_count[i] == db_last);
            hold_next[i] = hold_count[i] + hold_width'(1);
            if (rep_state[i] == DELAY) begin
                hold_hit[i] = (hold_next[i] == delay_target);
            end else begin
                hold_hit[i] = (hold_next[i] == period_target);
            end
        end
        level_next = key_level ^ flip;
    end

    // Two-flop synchronizer: key_raw is asynchronous to clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= key_raw;
            sync      <= sync_meta;
        end
    end

    // Debounce: any cycle where sync agrees with the accepted level restarts
    // the count, so a bounce must settle for the full window before it is
    // accepted. The edge pulses and any_key are registered alongside the
    // level so all of them change in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_key     <= 1'b0;
            for (int i = 0; i < w_key; i++) begin
                db_count[i] <= '0;
            end
        end else begin
            key_level   <= level_next;
            key_press   <= flip & ~key_level;
            key_release <= flip & key_level;
            any_key     <= |level_next;
            for (int i = 0; i < w_key; i++) begin
                if ((sync[i] == key_level[i]) || flip[i]) begin
                    db_count[i] <= '0;
                end else begin
                    db_count[i] <= db_count[i] + db_width'(1);
                end
            end
        end
    end

    // Auto-repeat FSM per key. A debounced edge in either direction restarts
    // the full delay. While the key is up or repeat is disabled, the FSM is
    // parked in DELAY with a cleared count, so a repeat pulse can never
    // coincide with a release or an idle key.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_repeat <= '0;
            for (int i = 0; i < w_key; i++) begin
                hold_count[i] <= '0;
                rep_state[i]  <= DELAY;
            end
        end else begin
            for (int i = 0; i < w_key; i++) begin
                key_repeat[i] <= 1'b0;
                if (flip[i] || !key_level[i] || !repeat_en) begin
                    hold_count[i] <= '0;
                    rep_state[i]  <= DELAY;
                end else if (hold_hit[i]) begin
                    key_repeat[i] <= 1'b1;
                    hold_count[i] <= '0;
                    rep_state[i]  <= PERIOD;
                end else begin
                    hold_count[i] <= hold_next[i];
                end
            end
        end
    end

endmodule
